// File: rtl/imem_dmem_arbiter.sv
// Arbitrates one unified single-port memory between instruction fetch (i) and load/store (d).
// Define IMEM_DMEM_ARBITER_DEBUG_PORT_EN to add a strict-priority debug/boot requester (g).
module imem_dmem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
`ifdef IMEM_DMEM_ARBITER_DEBUG_PORT_EN
  input  logic          g_req,
  input  logic          g_we,
  input  logic [AW-1:0] g_addr,
  input  logic [DW-1:0] g_wdata,
  output logic          g_gnt,
  output logic          g_rvalid,
  output logic [DW-1:0] g_rdata,
`endif
  output logic          m_en,
  output logic          m_we,
  output logic [AW-3:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT} state_t;
  typedef enum logic [1:0] {OWN_I, OWN_D, OWN_G} owner_t;

  localparam logic [1:0] CNT_LAST = 2'(MEM_LAT - 1);

  state_t          state_q, state_d;
  owner_t          owner_q, owner_d;
  logic            we_q, we_d;
  logic [AW-3:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [1:0]      cnt_q, cnt_d;
  logic            prio_d_q, prio_d_d;
  logic            i_gnt_q, i_gnt_d, d_gnt_q, d_gnt_d;
  logic            i_rvalid_q, i_rvalid_d, d_rvalid_q, d_rvalid_d;
  logic [DW-1:0]   i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic            sel_i, sel_d, rd_done;
`ifdef IMEM_DMEM_ARBITER_DEBUG_PORT_EN
  logic            sel_g;
  logic            g_gnt_q, g_gnt_d, g_rvalid_q, g_rvalid_d;
  logic [DW-1:0]   g_rdata_q, g_rdata_d;
  logic            addr_lsb_unused;
  assign addr_lsb_unused = ^{i_addr[1:0], d_addr[1:0], g_addr[1:0]};
`else
  logic            addr_lsb_unused;
  assign addr_lsb_unused = ^{i_addr[1:0], d_addr[1:0]};
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      owner_q    <= OWN_I;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      prio_d_q   <= 1'b1;
      i_gnt_q    <= 1'b0;
      d_gnt_q    <= 1'b0;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
`ifdef IMEM_DMEM_ARBITER_DEBUG_PORT_EN
      g_gnt_q    <= 1'b0;
      g_rvalid_q <= 1'b0;
      g_rdata_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      prio_d_q   <= prio_d_d;
      i_gnt_q    <= i_gnt_d;
      d_gnt_q    <= d_gnt_d;
      i_rvalid_q <= i_rvalid_d;
      d_rvalid_q <= d_rvalid_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
`ifdef IMEM_DMEM_ARBITER_DEBUG_PORT_EN
      g_gnt_q    <= g_gnt_d;
      g_rvalid_q <= g_rvalid_d;
      g_rdata_q  <= g_rdata_d;
`endif
    end
  end

  // Requests are only sampled in IDLE; the pointer (prio_d_q) decides ties between i and d.
  always_comb begin
    state_d = state_q;
    sel_i   = 1'b0;
    sel_d   = 1'b0;
`ifdef IMEM_DMEM_ARBITER_DEBUG_PORT_EN
    sel_g   = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
`ifdef IMEM_DMEM_ARBITER_DEBUG_PORT_EN
        if (g_req) sel_g = 1'b1;
        else
`endif
        if (i_req && d_req) begin
          sel_d = prio_d_q;
          sel_i = !prio_d_q;
        end else begin
          sel_i = i_req;
          sel_d = d_req;
        end
`ifdef IMEM_DMEM_ARBITER_DEBUG_PORT_EN
        if (sel_i || sel_d || sel_g) state_d = S_ACCESS;
`else
        if (sel_i || sel_d) state_d = S_ACCESS;
`endif
      end
      S_ACCESS: state_d = S_WAIT;
      S_WAIT:   if (cnt_q == CNT_LAST) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    m_en    = (state_q == S_ACCESS);
    m_we    = m_en & we_q;
    m_addr  = m_en ? addr_q : '0;
    m_wdata = m_en ? wdata_q : '0;
    busy    = (state_q != S_IDLE);

    cnt_d    = (state_q == S_WAIT) ? cnt_q + 2'd1 : 2'd0;
    owner_d  = owner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    prio_d_d = prio_d_q;
`ifdef IMEM_DMEM_ARBITER_DEBUG_PORT_EN
    if (sel_g) begin
      owner_d = OWN_G;
      we_d    = g_we;
      addr_d  = g_addr[AW-1:2];
      wdata_d = g_wdata;
    end else
`endif
    if (sel_d) begin
      owner_d  = OWN_D;
      we_d     = d_we;
      addr_d   = d_addr[AW-1:2];
      wdata_d  = d_wdata;
      prio_d_d = 1'b0;
    end else if (sel_i) begin
      owner_d  = OWN_I;
      we_d     = 1'b0;
      addr_d   = i_addr[AW-1:2];
      wdata_d  = '0;
      prio_d_d = 1'b1;
    end

    i_gnt_d = sel_i;
    d_gnt_d = sel_d;

    // m_rdata is valid in the last WAIT cycle; rvalid then appears in the following IDLE cycle.
    rd_done    = (state_q == S_WAIT) && (cnt_q == CNT_LAST);
    i_rvalid_d = rd_done && (owner_q == OWN_I);
    d_rvalid_d = rd_done && (owner_q == OWN_D);
    i_rdata_d  = i_rvalid_d ? m_rdata : i_rdata_q;
    d_rdata_d  = d_rvalid_d ? (we_q ? '0 : m_rdata) : d_rdata_q;
`ifdef IMEM_DMEM_ARBITER_DEBUG_PORT_EN
    g_gnt_d    = sel_g;
    g_rvalid_d = rd_done && (owner_q == OWN_G);
    g_rdata_d  = g_rvalid_d ? (we_q ? '0 : m_rdata) : g_rdata_q;
`endif
  end

  assign i_gnt    = i_gnt_q;
  assign d_gnt    = d_gnt_q;
  assign i_rvalid = i_rvalid_q;
  assign d_rvalid = d_rvalid_q;
  assign i_rdata  = i_rdata_q;
  assign d_rdata  = d_rdata_q;
`ifdef IMEM_DMEM_ARBITER_DEBUG_PORT_EN
  assign g_gnt    = g_gnt_q;
  assign g_rvalid = g_rvalid_q;
  assign g_rdata  = g_rdata_q;
`endif

endmodule

// File: doc/imem_dmem_arbiter.md
# imem_dmem_arbiter

Single-port memory arbiter for the CPU: it shares one unified word-addressed memory between the instruction-fetch requester and the data (load/store) requester. Each requester uses a req/gnt/rvalid handshake, and the block sequences exactly one memory transaction at a time with a programmable read latency. It sits between the CPU core (PC/IM path and ALU/DM path) and the memory macro. It replaces the separate IM/DM instances when the design moves to a unified memory.

## Interface
Parameters:
- AW, 32, byte-address width of both requesters.
- DW, 32, data width.
- MEM_LAT, 1, memory read latency in cycles (legal 1..4).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- i_req  in  1  instruction fetch request.
- i_addr  in  AW  fetch byte address.
- i_gnt  out  1  one-cycle grant pulse to fetch.
- i_rvalid  out  1  one-cycle fetch data valid.
- i_rdata  out  DW  fetch data.
- d_req  in  1  data request.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  AW  data byte address.
- d_wdata  in  DW  store data.
- d_gnt  out  1  one-cycle grant pulse to data.
- d_rvalid  out  1  load data valid, or store acknowledge.
- d_rdata  out  DW  load data; 0 on store acknowledge.
- m_en  out  1  memory access strobe.
- m_we  out  1  memory write enable.
- m_addr  out  AW-2  word address, equal to the request address [AW-1:2].
- m_wdata  out  DW  memory write data.
- m_rdata  in  DW  memory read data.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, ACCESS, WAIT.
- IDLE: samples i_req and d_req.
  - If either is high, the arbiter latches the winner's address, we and wdata, then moves to ACCESS.
- Arbitration is round-robin.
  - When both requesters are high, the winner is the one not served last.
  - A lone requester always wins.
  - The pointer updates on every grant.
  - After reset, the pointer favours data.
- ACCESS, one cycle: m_en=1 and m_we/m_addr/m_wdata are driven from the latched values. The winner's gnt=1 in this cycle. Next state is WAIT.
- WAIT: a counter counts MEM_LAT cycles.
  - In the last WAIT cycle, m_rdata is valid and is captured on the closing edge.
  - Next state is IDLE.
- In the first IDLE cycle after WAIT, the winner's rvalid=1 with its rdata (0 for stores). That IDLE cycle also arbitrates, so back-to-back transactions are allowed.
- Requesters hold req and fields stable until gnt.
  - req high in any IDLE cycle is a new request, including the rvalid cycle.
  - req seen in ACCESS or WAIT is ignored.
  - Dropping req before gnt is legal; no transaction is issued.
- addr[1:0] is ignored (no alignment check).
- m_we, m_addr and m_wdata are 0 when m_en=0.

## Timing
- Reset (asynchronous, immediate) sets:
  - state to IDLE and the pointer to data-first;
  - all outputs to 0: gnt, rvalid, rdata, m_*, busy.
- A reset in ACCESS or WAIT abandons the transaction; no rvalid follows.
- With req in cycle 0 (IDLE), the sequence is:
  - gnt and m_en in cycle 1;
  - m_rdata sampled at the end of cycle 1+MEM_LAT;
  - rvalid in cycle 2+MEM_LAT.
- Throughput is one transaction per MEM_LAT+2 cycles.
- i_rdata/d_rdata hold their value between rvalid pulses, except that d_rdata is 0 after a store acknowledge.
- gnt and rvalid are registered outputs.

## Configuration
- IMEM_DMEM_ARBITER_DEBUG_PORT_EN defined: adds a third requester for the boot loader/debugger, with ports g_req, g_we, g_addr, g_wdata, g_gnt, g_rvalid, g_rdata and the same handshake.
  - g has strict priority over i and d.
  - A g grant does not change the round-robin pointer.
- Undefined: the g ports and their logic are absent; behaviour is as described above.

## Test plan
- Reset:
  - Stimulus: assert reset low mid-WAIT, with MEM_LAT=2, after a d load.
  - Required: all outputs are 0 immediately; no d_rvalid in the following 5 cycles; busy=0.
- Fetch, MEM_LAT=1:
  - Stimulus: i_req with i_addr=0x0000_0010; memory returns 0xDEADBEEF.
  - Required: i_gnt and m_en in cycle 1 with m_addr=0x4; i_rvalid=1 with i_rdata=0xDEADBEEF in cycle 3.
- Store:
  - Stimulus: d_we=1, d_addr=0x20, d_wdata=0x1234_5678.
  - Required: m_we=1, m_addr=0x8, m_wdata=0x1234_5678 in cycle 1; d_rvalid in cycle 3 with d_rdata=0.
- Contention:
  - Stimulus: i_req and d_req both held high from reset release.
  - Required: grant order is D, I, D, I; grants are MEM_LAT+2 cycles apart; each rvalid goes to the matching requester.
- Latency and drop:
  - Stimulus: MEM_LAT=3; i_req pulsed for 1 cycle while busy, then a fetch.
  - Required: the pulse is ignored; the fetch's rvalid comes in cycle 5 after its req.
- Debug port (macro defined):
  - Stimulus: g, i and d all request together.
  - Required: g is granted first, then D, then I; the pointer is unaffected by the g grant.
